// File: rtl/input_stabilizer_bank.sv
// input_stabilizer_bank: N-channel synchronizer + debounce with registered rise/fall pulses.
// Define EVENT_LATCH_EN to add sticky per-channel rise flags (event_clr/event_flags).
module input_stabilizer_bank #(
  parameter int CHANNELS = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_LEN = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic nreset,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CHANNELS-1:0] debounce_en,
  output logic [CHANNELS-1:0] stable_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic any_change
`ifdef EVENT_LATCH_EN
  ,
  input  logic [CHANNELS-1:0] event_clr,
  output logic [CHANNELS-1:0] event_flags
`endif
);
  localparam int CW = $clog2(DEBOUNCE_LEN + 1);
  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0] stable_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  assign sync_q = sync_r[SYNC_STAGES-1];
  assign rise_d = stable_d & ~stable_out;
  assign fall_d = ~stable_d & stable_out;
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= RESET_VALUE;
    end else begin
      sync_r[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] len_m1;
    logic differ;
    logic done;
    assign len_m1 = debounce_en[c] ? CW'(DEBOUNCE_LEN - 1) : '0;
    assign differ = sync_q[c] ^ stable_out[c];
    // >= rather than == so dropping debounce_en mid-count accepts on that edge
    assign done = differ && (cnt >= len_m1);
    assign stable_d[c] = done ? sync_q[c] : stable_out[c];
    always_ff @(posedge clk) begin
      cnt <= (!nreset || !differ || done) ? '0 : cnt + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      stable_out <= RESET_VALUE;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
    end else begin
      stable_out <= stable_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      any_change <= |(rise_d | fall_d);
    end
  end
`ifdef EVENT_LATCH_EN
  always_ff @(posedge clk) begin
    event_flags <= !nreset ? '0 : rise_d | (event_flags & ~event_clr);
  end
`endif
endmodule

// File: tb/tb_input_stabilizer_bank.sv
// tb_input_stabilizer_bank: scoreboard bench with a cycle model plus directed timing checks.
module tb_input_stabilizer_bank;
  localparam int CH = 8;
  localparam int SS = 2;
  localparam int DL = 4;
  localparam logic [CH-1:0] RV = 8'h01;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [CH-1:0] async_in = '0;
  logic [CH-1:0] debounce_en = '0;
  logic [CH-1:0] stable_out, rise_pulse, fall_pulse;
  logic any_change;
  logic [CH-1:0] event_clr = '0;
`ifdef EVENT_LATCH_EN
  logic [CH-1:0] event_flags;
`endif
  input_stabilizer_bank #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_LEN(DL), .RESET_VALUE(RV)) dut (
    .clk(clk),
    .nreset(nreset),
    .async_in(async_in),
    .debounce_en(debounce_en),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
`ifdef EVENT_LATCH_EN
    ,
    .event_clr(event_clr),
    .event_flags(event_flags)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [CH-1:0] st;
    logic [CH-1:0] rp;
    logic [CH-1:0] fp;
    logic ac;
    logic [CH-1:0] fl;
  } exp_t;
  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [CH-1:0] m_sync [SS];
  logic [CH-1:0] m_st = RV;
  logic [CH-1:0] m_fl = '0;
  int m_run [CH];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    exp_t e;
    logic [CH-1:0] q, nst;
    e = '0;
    q = m_sync[SS-1];
    if (!nreset) begin
      for (int k = 0; k < SS; k++) m_sync[k] = RV;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
      m_st = RV;
      m_fl = '0;
      e.st = RV;
    end else begin
      nst = m_st;
      for (int i = 0; i < CH; i++) begin
        if (q[i] == m_st[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= (debounce_en[i] ? DL : 1)) begin
          nst[i] = q[i];
          m_run[i] = 0;
        end else m_run[i]++;
      end
      for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = async_in;
      e.st = nst;
      e.rp = nst & ~m_st;
      e.fp = m_st & ~nst;
      e.ac = |(e.rp | e.fp);
      m_fl = e.rp | (m_fl & ~event_clr);
      e.fl = m_fl;
      m_st = nst;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("stable_out", stable_out, e.st);
    check("rise_pulse", rise_pulse, e.rp);
    check("fall_pulse", fall_pulse, e.fp);
    check("any_change", any_change, e.ac);
    if (rise_pulse & fall_pulse) check("rise_and_fall", rise_pulse & fall_pulse, 0);
`ifdef EVENT_LATCH_EN
    check("event_flags", event_flags, e.fl);
`endif
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    for (int k = 0; k < SS; k++) m_sync[k] = RV;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
    // reset with all inputs high
    nreset = 1'b0;
    async_in = 8'hFF;
    steps(3);
    check("t1_reset_stable", stable_out, 8'h01);
    check("t1_reset_any", any_change, 0);
    nreset = 1'b1;
    step();
    check("t1_release_stable", stable_out, 8'h01);
    check("t1_release_pulses", rise_pulse | fall_pulse, 0);
    async_in = 8'h01;
    steps(8);
    check("t1_settled", stable_out, 8'h01);
    // bypass latency
    async_in = 8'h09;
    steps(2);
    check("t2_edge2", stable_out, 8'h01);
    step();
    check("t2_edge3", stable_out, 8'h09);
    check("t2_rise", rise_pulse, 8'h08);
    check("t2_any", any_change, 1);
    step();
    check("t2_rise_gone", rise_pulse, 8'h00);
    check("t2_any_gone", any_change, 0);
    // debounce: short pulse rejected, long one accepted at edge 6
    debounce_en = 8'hFF;
    async_in = 8'h29;
    steps(3);
    async_in = 8'h09;
    steps(6);
    check("t3_glitch", stable_out, 8'h09);
    async_in = 8'h29;
    steps(5);
    check("t3_edge5", stable_out, 8'h09);
    step();
    check("t3_edge6", stable_out, 8'h29);
    check("t3_rise", rise_pulse, 8'h20);
    step();
    check("t3_rise_gone", rise_pulse, 8'h00);
    // simultaneous rise/fall on different channels
    debounce_en = 8'h00;
    async_in = 8'h01;
    steps(4);
    check("t4_pre", stable_out, 8'h01);
    async_in = 8'h80;
    steps(3);
    check("t4_stable", stable_out, 8'h80);
    check("t4_fall", fall_pulse, 8'h01);
    check("t4_rise", rise_pulse, 8'h80);
    check("t4_any", any_change, 1);
    // reset in the middle of a debounce count
    debounce_en = 8'hFF;
    async_in = 8'h84;
    steps(4);
    check("t5_midcount", stable_out, 8'h80);
    nreset = 1'b0;
    step();
    check("t5_reset", stable_out, 8'h01);
    nreset = 1'b1;
    steps(5);
    check("t5_edge5", stable_out[2], 0);
    step();
    check("t5_edge6", stable_out[2], 1);
    check("t5_fall0", fall_pulse, 8'h01);
    // dropping debounce_en mid-count accepts immediately
    async_in = 8'h04;
    steps(3);
    debounce_en = 8'h00;
    step();
    check("t7_bypass_drop", stable_out, 8'h04);
`ifdef EVENT_LATCH_EN
    event_clr = 8'hFF;
    step();
    event_clr = 8'h00;
    check("t6_cleared", event_flags, 8'h00);
    async_in = 8'h06;
    steps(3);
    check("t6_set", event_flags, 8'h02);
    steps(3);
    check("t6_hold", event_flags, 8'h02);
    async_in = 8'h04;
    steps(3);
    async_in = 8'h06;
    steps(2);
    event_clr = 8'h02;
    step();
    check("t6_set_wins_rise", rise_pulse, 8'h02);
    check("t6_set_wins", event_flags, 8'h02);
    event_clr = 8'h00;
    step();
    event_clr = 8'h02;
    step();
    event_clr = 8'h00;
    check("t6_clear", event_flags, 8'h00);
`endif
    // random stress against the model
    for (int n = 0; n < 400; n++) begin
      async_in = async_in ^ CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) debounce_en = CH'($urandom);
      event_clr = CH'($urandom & $urandom);
      nreset = ($urandom_range(0, 63) != 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
